// File: rtl/dmem_pkg.sv
// Shared definitions for the pipelined data memory: size encodings, FSM state,
// latency bounds, the response stage record and store lane helpers.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;

  typedef logic [0:0] state_t;
  localparam state_t CLEAR = 1'b0;
  localparam state_t RUN   = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } stage_t;

  // Misalignment or illegal size; range errors are checked by the top.
  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate right-aligned store data so every enabled lane sees its bytes.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SZ_BYTE: return {4{wdata[7:0]}};
      SZ_HALF: return {2{wdata[15:0]}};
      default: return wdata;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load path lane select: moves the addressed byte/half to bit 0 and extends it.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[{off, 3'b000} +: 8];
    lane_h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: data = {{24{lane_b[7] & ~is_unsigned}}, lane_b};
      SZ_HALF: data = {{16{lane_h[15] & ~is_unsigned}}, lane_h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_pipe.sv
// Byte-addressed data memory with a fixed-latency in-order response pipeline.
// After reset the whole array is zeroed one word per cycle before requests are taken.
module data_mem_pipe
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2048,
  parameter int LAT    = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int AW = $clog2(DEPTH);

  if (DATA_W != 32) begin : g_bad_width
    $error("data_mem_pipe: DATA_W must be 32");
  end
  if (DEPTH < 16 || DEPTH > 65536 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("data_mem_pipe: DEPTH must be a power of two in 16..65536");
  end
  if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
    $error("data_mem_pipe: LAT out of range");
  end

  state_t        state_reg;
  logic [AW-1:0] clr_idx_reg;
  logic          accept;
  logic          req_err;
  logic [AW-1:0] word_idx;

  assign req_ready = (state_reg == RUN);
  assign init_done = (state_reg == RUN);
  assign accept    = req_valid & req_ready;
  assign word_idx  = req_addr[AW+1:2];
  assign req_err   = (|req_addr[31:AW+2]) | access_err(req_size, req_addr[1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= CLEAR;
      clr_idx_reg <= '0;
    end else if (state_reg == CLEAR) begin
      clr_idx_reg <= clr_idx_reg + 1'b1;
      if (clr_idx_reg == AW'(DEPTH - 1)) state_reg <= RUN;
    end
  end

  // Single write port shared by the clear sweep and committed stores.
  logic [3:0][7:0] mem [DEPTH];
  logic            mem_we;
  logic [AW-1:0]   mem_idx;
  logic [3:0]      mem_be;
  logic [3:0][7:0] mem_wdata;
  logic [31:0]     raw_reg;

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = word_idx;
    mem_be    = store_be(req_size, req_addr[1:0]);
    mem_wdata = store_lanes(req_size, req_wdata);
    if (state_reg == CLEAR) begin
      mem_we    = 1'b1;
      mem_idx   = clr_idx_reg;
      mem_be    = 4'b1111;
      mem_wdata = '0;
    end else if (accept && req_we && !req_err) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][b] <= mem_wdata[b];
      end
    end
    if (accept) raw_reg <= mem[word_idx];
  end

  // First stage carries the request attributes alongside the registered read.
  logic       v1_reg;
  logic       e1_reg;
  logic       ld1_reg;
  logic       uns1_reg;
  logic [1:0] off1_reg;
  logic [1:0] size1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg    <= 1'b0;
      e1_reg    <= 1'b0;
      ld1_reg   <= 1'b0;
      uns1_reg  <= 1'b0;
      off1_reg  <= 2'b00;
      size1_reg <= 2'b00;
    end else begin
      v1_reg    <= accept;
      e1_reg    <= accept & req_err;
      ld1_reg   <= accept & ~req_we & ~req_err;
      uns1_reg  <= req_unsigned;
      off1_reg  <= req_addr[1:0];
      size1_reg <= req_size;
    end
  end

  logic [31:0] aligned;

  dmem_load_align u_align (
    .word        (raw_reg),
    .off         (off1_reg),
    .size        (size1_reg),
    .is_unsigned (uns1_reg),
    .data        (aligned)
  );

  stage_t stage_out [1:LAT];

  assign stage_out[1] = {v1_reg, e1_reg, (ld1_reg ? aligned : 32'd0)};

  genvar gi;
  for (gi = 2; gi <= LAT; gi++) begin : g_stage
    stage_t q_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q_reg <= '0;
      else        q_reg <= stage_out[gi-1];
    end
    assign stage_out[gi] = q_reg;
  end

  assign resp_valid = stage_out[LAT].valid;
  assign resp_err   = stage_out[LAT].err;
  assign resp_rdata = stage_out[LAT].rdata;

endmodule
